config_access_arbiter: RTL and testbench

//  Shares the smart-home configuration memory write port between NREQ user panels.

---
 rtl/config_access_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_config_access_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_access_arbiter.sv
// Round-robin arbiter sharing the configuration memory write port between panels,
// with password check against syskey and per-panel lockout after repeated mismatches.
module config_access_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned CFG_W       = 35,
    parameter int unsigned KEY_W       = 2,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*KEY_W-1:0] pass_bus,
    input  logic [NREQ*CFG_W-1:0] cfg_bus,
    input  logic [KEY_W-1:0]      syskey,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       nack,
    output logic [CFG_W-1:0]      cfg_out,
    output logic                  write_en,
    output logic [NREQ-1:0]       locked,
    output logic [2:0]            dbg_state
);

    localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned FAIL_W = 3;
    localparam int unsigned TMR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_CHECK   = 3'b010,
        ST_WRITE   = 3'b011,
        ST_RELEASE = 3'b100,
        ST_DENY    = 3'b101
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [NREQ-1:0]    nack_q, nack_d;
    logic [CFG_W-1:0]   cfg_out_q, cfg_out_d;
    logic               write_en_q, write_en_d;
    logic [NREQ-1:0]    locked_q, locked_d;
    logic [FAIL_W-1:0]  fail_q [NREQ];
    logic [FAIL_W-1:0]  fail_d [NREQ];
    logic [TMR_W-1:0]   timer_q [NREQ];
    logic [TMR_W-1:0]   timer_d [NREQ];

    logic [KEY_W-1:0]   pass_a [NREQ];
    logic [CFG_W-1:0]   cfg_a [NREQ];
    logic [NREQ-1:0]    eligible;
    logic               found;
    logic [ID_W-1:0]    pick;
    int unsigned        idx;
    logic [FAIL_W-1:0]  fail_cnt;

    // Split the flat panel buses into per-panel words
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pass_a[i] = pass_bus[i*KEY_W +: KEY_W];
            cfg_a[i]  = cfg_bus[i*CFG_W +: CFG_W];
        end
    end

    // Next-state, arbitration, fail counters and lock timers
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        nack_d     = '0;
        write_en_d = 1'b0;
        cfg_out_d  = cfg_out_q;
        found      = 1'b0;
        pick       = '0;
        idx        = 0;
        fail_cnt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            fail_d[i]  = fail_q[i];
            timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - TMR_W'(1) : '0;
        end

        // Registered lock state is used, so a lock expiring this cycle still excludes
        eligible = req & ~locked_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && eligible[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_id_d = pick;
                    gnt_d    = NREQ'(1) << pick;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!req[gnt_id_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (pass_a[gnt_id_q] == syskey) begin
                    state_d          = ST_WRITE;
                    cfg_out_d        = cfg_a[gnt_id_q];
                    write_en_d       = 1'b1;
                    ack_d            = gnt_q;
                    fail_d[gnt_id_q] = '0;
                end else begin
                    state_d  = ST_DENY;
                    nack_d   = gnt_q;
                    fail_cnt = fail_q[gnt_id_q] + FAIL_W'(1);
                    if (fail_cnt == FAIL_W'(MAX_FAIL)) begin
                        fail_d[gnt_id_q]  = '0;
                        timer_d[gnt_id_q] = TMR_W'(LOCK_CYCLES);
                    end else begin
                        fail_d[gnt_id_q] = fail_cnt;
                    end
                end
            end
            ST_WRITE, ST_DENY: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!req[gnt_id_q]) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = (gnt_id_q == ID_W'(NREQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        for (int i = 0; i < NREQ; i++) begin
            locked_d[i] = (timer_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_IDLE;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            nack_q     <= '0;
            cfg_out_q  <= '0;
            write_en_q <= 1'b0;
            locked_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                fail_q[i]  <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            cfg_out_q  <= cfg_out_d;
            write_en_q <= write_en_d;
            locked_q   <= locked_d;
            for (int i = 0; i < NREQ; i++) begin
                fail_q[i]  <= fail_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign nack      = nack_q;
    assign cfg_out   = cfg_out_q;
    assign write_en  = write_en_q;
    assign locked    = locked_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_config_access_arbiter.sv
// Randomized bench for config_access_arbiter against a transaction-level model
// tracking absolute lock-expiry edges, fail counts and the round-robin pointer.
module tb_config_access_arbiter;

    localparam int unsigned NREQ        = 3;
    localparam int unsigned CFG_W       = 35;
    localparam int unsigned KEY_W       = 2;
    localparam int unsigned MAX_FAIL    = 3;
    localparam int unsigned LOCK_CYCLES = 16;

    logic                  clk = 1'b0;
    logic                  arst = 1'b0;
    logic [NREQ-1:0]       req;
    logic [NREQ*KEY_W-1:0] pass_bus;
    logic [NREQ*CFG_W-1:0] cfg_bus;
    logic [KEY_W-1:0]      syskey;
    logic [NREQ-1:0]       gnt, ack, nack, locked;
    logic [CFG_W-1:0]      cfg_out;
    logic                  write_en;
    logic [2:0]            dbg_state;

    logic [KEY_W-1:0] pass_m [NREQ];
    logic [CFG_W-1:0] cfg_m [NREQ];

    // Model state: edge index from which each panel is eligible again, fail counts, rr pointer
    int cyc = 0;
    int ready;
    int free_edge [NREQ];
    int fail_m [NREQ];
    int rr_m;
    logic [CFG_W-1:0] last_cfg;
    int n_chk = 0;
    int n_fail = 0;
    bit hung = 1'b0;

    config_access_arbiter #(
        .NREQ(NREQ), .CFG_W(CFG_W), .KEY_W(KEY_W),
        .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .arst(arst), .req(req), .pass_bus(pass_bus), .cfg_bus(cfg_bus),
        .syskey(syskey), .gnt(gnt), .ack(ack), .nack(nack), .cfg_out(cfg_out),
        .write_en(write_en), .locked(locked), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pass_bus[i*KEY_W +: KEY_W] = pass_m[i];
            cfg_bus[i*CFG_W +: CFG_W]  = cfg_m[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_locked();
        logic [NREQ-1:0] exp;
        exp = '0;
        for (int i = 0; i < NREQ; i++) if (cyc < free_edge[i] - 1) exp[i] = 1'b1;
        chk("locked", locked, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            free_edge[i] = 0;
            fail_m[i]    = 0;
        end
        rr_m     = 0;
        last_cfg = '0;
    endtask

    task automatic new_request(input int i);
        req[i]   = 1'b1;
        cfg_m[i] = CFG_W'({$urandom, $urandom});
    endtask

    // One arbitration transaction: fid<0 means random requesters/passwords
    task automatic do_round(input int fid, input bit fok, input logic [CFG_W-1:0] fcfg,
                            input bit rst_in_write);
        int e, w, m, j;
        logic [NREQ-1:0] wmask;
        if (fid >= 0) begin
            syskey      = 2'b10;
            req         = '0;
            req[fid]    = 1'b1;
            pass_m[fid] = fok ? syskey : ~syskey;
            cfg_m[fid]  = fcfg;
        end else begin
            syskey = KEY_W'($urandom);
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 1) == 1) new_request(i);
            if (req == '0) new_request(int'($urandom_range(0, NREQ - 1)));
            for (int i = 0; i < NREQ; i++)
                pass_m[i] = ($urandom_range(0, 9) < 6) ? syskey : KEY_W'($urandom);
        end

        e = ready;
        m = 1 << 30;
        for (int i = 0; i < NREQ; i++) if (req[i] && free_edge[i] < m) m = free_edge[i];
        if (m > e) e = m;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (rr_m + k) % NREQ;
            if (w < 0 && req[j] && free_edge[j] <= e) w = j;
        end
        wmask = NREQ'(1) << w;

        for (int a = 0; a < 200; a++) begin
            @(negedge clk);
            if (gnt != '0) break;
            chk_locked();
        end
        chk("arb_edge", 64'(cyc), 64'(e));
        if (gnt == '0) begin
            chk("grant_timeout", 64'(gnt), 64'(wmask));
            hung = 1'b1;
            return;
        end
        chk("gnt", gnt, wmask);
        chk("st_check", dbg_state, 3'b010);
        chk("we_at_gnt", write_en, 0);

        if (fid < 0 && $urandom_range(0, 9) == 0) begin
            req[w] = 1'b0;
            @(negedge clk);
            chk("abort_gnt", gnt, 0);
            chk("abort_st", dbg_state, 3'b001);
            chk("abort_pulses", {ack, nack, write_en}, 0);
            chk_locked();
            ready = cyc + 1;
            return;
        end

        @(negedge clk);
        if (pass_m[w] == syskey) begin
            chk("we", write_en, 1);
            chk("ack", ack, wmask);
            chk("nack0", nack, 0);
            chk("cfg_out", cfg_out, cfg_m[w]);
            chk("st_write", dbg_state, 3'b011);
            fail_m[w] = 0;
            last_cfg  = cfg_m[w];
        end else begin
            chk("nack", nack, wmask);
            chk("ack0", ack, 0);
            chk("we0", write_en, 0);
            chk("cfg_hold", cfg_out, last_cfg);
            chk("st_deny", dbg_state, 3'b101);
            fail_m[w]++;
            if (fail_m[w] == MAX_FAIL) begin
                fail_m[w]    = 0;
                free_edge[w] = cyc + LOCK_CYCLES + 1;
            end
        end
        chk_locked();

        if (rst_in_write) begin
            #2 arst = 1'b0;
            #1;
            chk("rst_we", write_en, 0);
            chk("rst_gnt", gnt, 0);
            chk("rst_st", dbg_state, 3'b001);
            chk("rst_locked", locked, 0);
            chk("rst_pulses", {ack, nack}, 0);
            model_reset();
            req = '0;
            @(negedge clk);
            @(negedge clk);
            arst  = 1'b1;
            ready = cyc + 1;
            return;
        end

        req[w] = 1'b0;
        @(negedge clk);
        chk("pulse_drop", {ack, nack, write_en}, 0);
        chk("st_release", dbg_state, 3'b100);
        chk("gnt_hold", gnt, wmask);
        chk_locked();
        @(negedge clk);
        chk("gnt_clear", gnt, 0);
        chk("st_idle", dbg_state, 3'b001);
        chk_locked();
        rr_m  = (w + 1) % NREQ;
        ready = cyc + 1;
    endtask

    initial begin
        req    = '0;
        syskey = '0;
        for (int i = 0; i < NREQ; i++) begin
            pass_m[i] = '0;
            cfg_m[i]  = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outs", {gnt, ack, nack, write_en, locked}, 0);
        chk("reset_cfg", cfg_out, 0);
        chk("reset_st", dbg_state, 3'b001);
        arst  = 1'b1;
        ready = cyc + 1;

        do_round(0, 1'b1, 35'h1234, 1'b0);
        repeat (3) do_round(1, 1'b0, 35'h0, 1'b0);
        do_round(1, 1'b1, 35'h4_0000_0001, 1'b0);
        do_round(0, 1'b0, 35'h0, 1'b0);
        do_round(0, 1'b0, 35'h0, 1'b0);
        do_round(0, 1'b1, 35'h7_ABCD_0123, 1'b0);
        do_round(0, 1'b0, 35'h0, 1'b0);

        for (int r = 0; r < 200 && !hung; r++) do_round(-1, 1'b0, 35'h0, 1'b0);

        if (!hung) begin
            repeat (3) do_round(2, 1'b0, 35'h0, 1'b0);
            do_round(0, 1'b1, 35'h5_A5A5, 1'b1);
            do_round(2, 1'b1, 35'h777, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
